// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: FSM states,
// scan-code prefix bytes and Hack key codes for the non-printable keys.
package keyboard_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    localparam logic [15:0] KEY_SPACE     = 16'd32;
    localparam logic [15:0] KEY_NEWLINE   = 16'd128;
    localparam logic [15:0] KEY_BACKSPACE = 16'd129;
    localparam logic [15:0] KEY_LEFT      = 16'd130;
    localparam logic [15:0] KEY_UP        = 16'd131;
    localparam logic [15:0] KEY_RIGHT     = 16'd132;
    localparam logic [15:0] KEY_DOWN      = 16'd133;
    localparam logic [15:0] KEY_HOME      = 16'd134;
    localparam logic [15:0] KEY_END       = 16'd135;
    localparam logic [15:0] KEY_PGUP      = 16'd136;
    localparam logic [15:0] KEY_PGDN      = 16'd137;
    localparam logic [15:0] KEY_INSERT    = 16'd138;
    localparam logic [15:0] KEY_DELETE    = 16'd139;
    localparam logic [15:0] KEY_ESC       = 16'd140;
    localparam logic [15:0] KEY_F1        = 16'd141;
    localparam logic [15:0] KEY_F2        = 16'd142;
    localparam logic [15:0] KEY_F3        = 16'd143;
    localparam logic [15:0] KEY_F4        = 16'd144;
    localparam logic [15:0] KEY_F5        = 16'd145;
    localparam logic [15:0] KEY_F6        = 16'd146;
    localparam logic [15:0] KEY_F7        = 16'd147;
    localparam logic [15:0] KEY_F8        = 16'd148;
    localparam logic [15:0] KEY_F9        = 16'd149;
    localparam logic [15:0] KEY_F10       = 16'd150;
    localparam logic [15:0] KEY_F11       = 16'd151;
    localparam logic [15:0] KEY_F12       = 16'd152;

    // Printable keys map straight to their ASCII value.
    function automatic logic [15:0] ascii(input logic [7:0] c);
        return {8'h00, c};
    endfunction

endpackage

// File: rtl/scancode_map.sv
// Combinational scan-code set 2 to Hack key code translation.
// ext_i selects the E0-prefixed table; anything not listed maps to 0.
module scancode_map
    import keyboard_pkg::*;
(
    input  logic        ext_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] code_o
);

    always_comb begin
        code_o = 16'd0;
        if (ext_i) begin
            case (byte_i)
                8'h6B:   code_o = KEY_LEFT;
                8'h75:   code_o = KEY_UP;
                8'h74:   code_o = KEY_RIGHT;
                8'h72:   code_o = KEY_DOWN;
                8'h6C:   code_o = KEY_HOME;
                8'h69:   code_o = KEY_END;
                8'h7D:   code_o = KEY_PGUP;
                8'h7A:   code_o = KEY_PGDN;
                8'h70:   code_o = KEY_INSERT;
                8'h71:   code_o = KEY_DELETE;
                default: code_o = 16'd0;
            endcase
        end else begin
            case (byte_i)
                8'h1C:   code_o = ascii(8'd65);  // A
                8'h32:   code_o = ascii(8'd66);
                8'h21:   code_o = ascii(8'd67);
                8'h23:   code_o = ascii(8'd68);
                8'h24:   code_o = ascii(8'd69);
                8'h2B:   code_o = ascii(8'd70);
                8'h34:   code_o = ascii(8'd71);
                8'h33:   code_o = ascii(8'd72);
                8'h43:   code_o = ascii(8'd73);
                8'h3B:   code_o = ascii(8'd74);
                8'h42:   code_o = ascii(8'd75);
                8'h4B:   code_o = ascii(8'd76);
                8'h3A:   code_o = ascii(8'd77);
                8'h31:   code_o = ascii(8'd78);
                8'h44:   code_o = ascii(8'd79);
                8'h4D:   code_o = ascii(8'd80);
                8'h15:   code_o = ascii(8'd81);
                8'h2D:   code_o = ascii(8'd82);
                8'h1B:   code_o = ascii(8'd83);
                8'h2C:   code_o = ascii(8'd84);
                8'h3C:   code_o = ascii(8'd85);
                8'h2A:   code_o = ascii(8'd86);
                8'h1D:   code_o = ascii(8'd87);
                8'h22:   code_o = ascii(8'd88);
                8'h35:   code_o = ascii(8'd89);
                8'h1A:   code_o = ascii(8'd90);  // Z
                8'h45:   code_o = ascii(8'd48);  // 0
                8'h16:   code_o = ascii(8'd49);
                8'h1E:   code_o = ascii(8'd50);
                8'h26:   code_o = ascii(8'd51);
                8'h25:   code_o = ascii(8'd52);
                8'h2E:   code_o = ascii(8'd53);
                8'h36:   code_o = ascii(8'd54);
                8'h3D:   code_o = ascii(8'd55);
                8'h3E:   code_o = ascii(8'd56);
                8'h46:   code_o = ascii(8'd57);  // 9
                8'h29:   code_o = KEY_SPACE;
                8'h5A:   code_o = KEY_NEWLINE;
                8'h66:   code_o = KEY_BACKSPACE;
                8'h76:   code_o = KEY_ESC;
                8'h05:   code_o = KEY_F1;
                8'h06:   code_o = KEY_F2;
                8'h04:   code_o = KEY_F3;
                8'h0C:   code_o = KEY_F4;
                8'h03:   code_o = KEY_F5;
                8'h0B:   code_o = KEY_F6;
                8'h83:   code_o = KEY_F7;
                8'h0A:   code_o = KEY_F8;
                8'h01:   code_o = KEY_F9;
                8'h09:   code_o = KEY_F10;
                8'h78:   code_o = KEY_F11;
                8'h07:   code_o = KEY_F12;
                default: code_o = 16'd0;
            endcase
        end
    end

endmodule

// File: rtl/keyboard_receiver.sv
// PS/2 keyboard receiver: frames bytes off the PS/2 lines and tracks the held
// Hack key code. Define PARITY_CHECK_EN to reject frames with bad odd parity.
module keyboard_receiver
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kb_out,
    output logic        byte_valid,
    output logic        frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic             clk_prev_q;
    logic             fall;
    logic             data_s;

    ps2_state_t       state_q;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic [2:0]       bit_cnt_q;
    logic [CNT_W-1:0] to_cnt_q;
    logic             timeout_hit;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [15:0]      kb_out_q, kb_out_d;
    logic             byte_valid_q;
    logic             frame_err_q;
    logic             parity_ok;
    logic [15:0]      code;

`ifdef PARITY_CHECK_EN
    logic             parity_q;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= {ps2_data, ps2_clk};
            sync_q     <= meta_q;
            clk_prev_q <= sync_q[0];
        end
    end

    assign fall        = clk_prev_q & ~sync_q[0];
    assign data_s      = sync_q[1];
    assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TO_LAST);
    assign shift_d     = {data_s, shift_q[7:1]};

    scancode_map u_map (
        .ext_i  (ext_q),
        .byte_i (shift_q),
        .code_o (code)
    );

    // Effect of accepting the byte currently held in shift_q.
    always_comb begin
        kb_out_d = kb_out_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        if (shift_q == PREFIX_EXT) begin
            ext_d = 1'b1;
        end else if (shift_q == PREFIX_BRK) begin
            brk_d = 1'b1;
        end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (brk_q) begin
                if (code == kb_out_q) begin
                    kb_out_d = 16'd0;
                end
            end else if (code != 16'd0) begin
                kb_out_d = code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            to_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            kb_out_q     <= 16'd0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q != IDLE) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end

            // Timeout wins over a coincident falling edge.
            if (timeout_hit) begin
                state_q     <= IDLE;
                to_cnt_q    <= '0;
                bit_cnt_q   <= 3'd0;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!data_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PARITY_CHECK_EN
                        parity_q <= data_s;
`endif
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (data_s && parity_ok) begin
                            byte_valid_q <= 1'b1;
                            kb_out_q     <= kb_out_d;
                            ext_q        <= ext_d;
                            brk_q        <= brk_d;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign kb_out     = kb_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_keyboard_receiver.sv
// Directed bench for keyboard_receiver: PS/2 frames driven bit by bit,
// key codes and pulse latency checked against hand-computed values.
module tb_keyboard_receiver;

    localparam int TO   = 300;
    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kb_out;
    logic        byte_valid;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int bv_count = 0;
    int fe_count = 0;
    int kb_glitch = 0;
    logic [15:0] kb_prev = 16'd0;

    always #5 clk = ~clk;

    keyboard_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .kb_out     (kb_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Pulse counters; kb_out may only move on a byte_valid cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid) bv_count++;
            if (frame_err) fe_count++;
            if (kb_out !== kb_prev && !byte_valid) kb_glitch++;
        end
        kb_prev = kb_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; pulses are sampled on the third negedge after the stop-bit
    // clock drop (2 sync flops, edge detect, registered output).
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                              output logic got_bv, output logic got_fe);
        logic [9:0] bits;
        bits = {(~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        @(negedge clk);
        ps2_data = stop_bit;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        got_bv = byte_valid;
        got_fe = frame_err;
        repeat (HALF - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        logic bv, fe;
        send_frame(b, 1'b0, 1'b1, bv, fe);
    endtask

    task automatic send_partial(input logic [7:0] b, input int ndata);
        ps2_bit(1'b0);
        for (int i = 0; i < ndata; i++) ps2_bit(b[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bv_count = 0;
        fe_count = 0;
        kb_glitch = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (kb_out !== 16'd0) begin failures++; $display("FAIL reset_kb_out: got %0d expected 0", kb_out); end
        checks++;
        if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        do_reset();
        $display("test_reset done: kb_out=%0d", kb_out);
    endtask

    task automatic test_make_a();
        logic bv, fe;
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1, bv, fe);
        checks++;
        if (bv !== 1'b1) begin failures++; $display("FAIL make_a_latency: byte_valid got %b expected 1 on 3rd cycle", bv); end
        checks++;
        if (fe !== 1'b0) begin failures++; $display("FAIL make_a_frame_err: got %b expected 0", fe); end
        checks++;
        if (kb_out !== 16'd65) begin failures++; $display("FAIL make_a_kb: got %0d expected 65", kb_out); end
        $display("test_make_a: byte 0x1C kb_out=%0d", kb_out);
    endtask

    task automatic test_make_break();
        logic [15:0] k1, k2;
        do_reset();
        send_ok(8'h1C);
        k1 = kb_out;
        send_ok(8'hF0);
        k2 = kb_out;
        send_ok(8'h1C);
        checks++;
        if (k1 !== 16'd65) begin failures++; $display("FAIL mb_make: got %0d expected 65", k1); end
        checks++;
        if (k2 !== 16'd65) begin failures++; $display("FAIL mb_prefix: got %0d expected 65", k2); end
        checks++;
        if (kb_out !== 16'd0) begin failures++; $display("FAIL mb_break: got %0d expected 0", kb_out); end
        checks++;
        if (bv_count !== 3) begin failures++; $display("FAIL mb_pulses: got %0d expected 3", bv_count); end
        checks++;
        if (kb_glitch !== 0) begin failures++; $display("FAIL mb_kb_timing: got %0d stray changes expected 0", kb_glitch); end
        $display("test_make_break: 1C F0 1C kb_out=%0d pulses=%0d", kb_out, bv_count);
    endtask

    task automatic test_ext();
        logic [15:0] k1;
        do_reset();
        send_ok(8'hE0);
        send_ok(8'h75);
        k1 = kb_out;
        send_ok(8'hF0);
        send_ok(8'h1C);
        checks++;
        if (k1 !== 16'd131) begin failures++; $display("FAIL ext_up: got %0d expected 131", k1); end
        checks++;
        if (kb_out !== 16'd131) begin failures++; $display("FAIL ext_release_other: got %0d expected 131", kb_out); end
        send_ok(8'hE0);
        send_ok(8'hF0);
        send_ok(8'h75);
        checks++;
        if (kb_out !== 16'd0) begin failures++; $display("FAIL ext_release_up: got %0d expected 0", kb_out); end
        $display("test_ext: E0 75 / F0 1C / E0 F0 75 kb_out=%0d", kb_out);
    endtask

    task automatic test_map();
        logic [7:0]  sc    [0:6];
        logic        ex    [0:6];
        logic [15:0] exp_k [0:6];
        sc    = '{8'h05, 8'h45, 8'h07, 8'h76, 8'h66, 8'h71, 8'h0E};
        ex    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_k = '{16'd141, 16'd48, 16'd152, 16'd140, 16'd129, 16'd139, 16'd139};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (ex[i]) send_ok(8'hE0);
            send_ok(sc[i]);
            checks++;
            if (kb_out !== exp_k[i]) begin
                failures++;
                $display("FAIL map_%0d: byte 0x%02h ext=%b got %0d expected %0d", i, sc[i], ex[i], kb_out, exp_k[i]);
            end
        end
        $display("test_map: %0d codes translated, kb_out=%0d", 7, kb_out);
    endtask

    task automatic test_parity();
        logic bv, fe;
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b1, bv, fe);
`ifdef PARITY_CHECK_EN
        checks++;
        if (fe !== 1'b1) begin failures++; $display("FAIL parity_err: frame_err got %b expected 1", fe); end
        checks++;
        if (kb_out !== 16'd0) begin failures++; $display("FAIL parity_kb: got %0d expected 0", kb_out); end
`else
        checks++;
        if (bv !== 1'b1) begin failures++; $display("FAIL parity_ignored: byte_valid got %b expected 1", bv); end
        checks++;
        if (kb_out !== 16'd65) begin failures++; $display("FAIL parity_kb: got %0d expected 65", kb_out); end
`endif
        $display("test_parity: bad parity 0x1C kb_out=%0d bv=%b fe=%b", kb_out, bv, fe);
    endtask

    task automatic test_bad_stop();
        logic bv, fe;
        do_reset();
        send_ok(8'h1C);
        send_ok(8'hE0);
        send_frame(8'h32, 1'b0, 1'b0, bv, fe);
        checks++;
        if (fe !== 1'b1 || bv !== 1'b0) begin
            failures++; $display("FAIL stop_reject: got fe=%b bv=%b expected fe=1 bv=0", fe, bv);
        end
        checks++;
        if (kb_out !== 16'd65) begin failures++; $display("FAIL stop_kb: got %0d expected 65", kb_out); end
        send_ok(8'h75);
        checks++;
        if (kb_out !== 16'd131) begin failures++; $display("FAIL stop_ext_kept: got %0d expected 131", kb_out); end
        $display("test_bad_stop: kb_out=%0d", kb_out);
    endtask

    task automatic test_timeout();
        int n;
        logic bv, fe;
        do_reset();
        send_partial(8'h5A, 4);
        n = 0;
        while (frame_err !== 1'b1 && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TO - HALF || n > TO - HALF + 5) begin
            failures++; $display("FAIL timeout_window: frame_err after %0d cycles expected %0d..%0d", n, TO - HALF, TO - HALF + 5);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (fe_count !== 1 || bv_count !== 0) begin
            failures++; $display("FAIL timeout_pulses: got fe=%0d bv=%0d expected fe=1 bv=0", fe_count, bv_count);
        end
        send_frame(8'h29, 1'b0, 1'b1, bv, fe);
        checks++;
        if (bv !== 1'b1 || kb_out !== 16'd32) begin
            failures++; $display("FAIL timeout_recover: got bv=%b kb=%0d expected bv=1 kb=32", bv, kb_out);
        end
        $display("test_timeout: abort after %0d cycles, then kb_out=%0d", n, kb_out);
    endtask

    task automatic test_reset_mid();
        logic bv, fe;
        do_reset();
        send_ok(8'h1C);
        send_partial(8'h5A, 5);
        do_reset();
        checks++;
        if (kb_out !== 16'd0) begin failures++; $display("FAIL midreset_kb: got %0d expected 0", kb_out); end
        send_frame(8'h5A, 1'b0, 1'b1, bv, fe);
        checks++;
        if (bv !== 1'b1 || kb_out !== 16'd128) begin
            failures++; $display("FAIL midreset_fresh: got bv=%b kb=%0d expected bv=1 kb=128", bv, kb_out);
        end
        $display("test_reset_mid: kb_out=%0d", kb_out);
    endtask

    initial begin
        test_reset();
        test_make_a();
        test_make_break();
        test_ext();
        test_map();
        test_parity();
        test_bad_stop();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
